// File: rtl/router_reg_gen.sv
// Router datapath register block: header latch/validation, write-bus forwarding with a small
// holding queue, XOR parity and payload-length checking. Optional macro: ROUTER_REG_ERRSTAT_EN.
module router_reg_gen #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned HOLD_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              pkt_valid,
  input  logic [DATA_W-1:0]                 data_in,
  input  logic                              detect_add,
  input  logic                              lfd_state,
  input  logic                              ld_state,
  input  logic                              laf_state,
  input  logic                              full_state,
  input  logic                              rst_int_reg,
  input  logic                              fifo_full,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_valid,
  output logic [ADDR_W-1:0]                 dest_addr,
  output logic                              invalid_addr,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_count,
  output logic                              hold_ovf,
  output logic                              low_packet_valid,
  output logic                              parity_done,
  output logic                              err,
  output logic                              len_err
`ifdef ROUTER_REG_ERRSTAT_EN
  ,
  output logic [15:0]                       err_cnt,
  output logic [15:0]                       len_err_cnt
`endif
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;
  localparam int unsigned PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(HOLD_DEPTH + 1);

  logic [DATA_W-1:0] r_header;
  logic [DATA_W-1:0] r_int_parity;
  logic [DATA_W-1:0] r_ext_parity;
  logic [LEN_W-1:0]  r_exp_len;
  logic [LEN_W-1:0]  r_pay_cnt;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_dout_par;
  logic [DATA_W-1:0] r_q_data [HOLD_DEPTH];
  logic              r_q_par  [HOLD_DEPTH];

  logic [ADDR_W-1:0] w_addr;
  logic              w_hdr_ok;
  logic              w_hdr_bad;
  logic              w_ld;
  logic              w_laf;
  logic              w_q_empty;
  logic              w_q_full;
  logic              w_direct;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    if (32'(p) == HOLD_DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_addr    = data_in[ADDR_W-1:0];
  assign w_hdr_ok  = detect_add & pkt_valid & (32'(w_addr) < NUM_PORTS);
  assign w_hdr_bad = detect_add & pkt_valid & (32'(w_addr) >= NUM_PORTS);
  assign w_ld      = ld_state & ~full_state;
  assign w_laf     = laf_state & ~full_state;
  assign w_q_empty = (hold_count == '0);
  assign w_q_full  = (hold_count == CNT_W'(HOLD_DEPTH));

  // A byte arriving while the queue holds data must go behind it to keep order.
  assign w_direct = w_ld & ~fifo_full & w_q_empty;
  assign w_pop    = (w_ld | w_laf) & ~fifo_full & ~w_q_empty;
  assign w_push   = w_ld & (fifo_full ? ~w_q_full : ~w_q_empty);
  assign w_drop   = w_ld & fifo_full & w_q_full;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= data_in;
      r_q_par[r_wr_ptr]  <= ~pkt_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_header         <= '0;
      r_int_parity     <= '0;
      r_ext_parity     <= '0;
      r_exp_len        <= '0;
      r_pay_cnt        <= '0;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_dout_par       <= 1'b0;
      dout             <= '0;
      dout_valid       <= 1'b0;
      dest_addr        <= '0;
      invalid_addr     <= 1'b0;
      hold_count       <= '0;
      hold_ovf         <= 1'b0;
      low_packet_valid <= 1'b0;
      parity_done      <= 1'b0;
      err              <= 1'b0;
      len_err          <= 1'b0;
    end else begin
      invalid_addr <= w_hdr_bad;
      dout_valid   <= lfd_state | w_pop | w_direct;

      if (w_hdr_ok) begin
        r_header  <= data_in;
        dest_addr <= w_addr;
      end

      // r_dout_par tags the byte on dout so parity_done can follow the parity byte out.
      if (lfd_state) begin
        dout       <= r_header;
        r_dout_par <= 1'b0;
      end else if (w_pop) begin
        dout       <= r_q_data[r_rd_ptr];
        r_dout_par <= r_q_par[r_rd_ptr];
      end else if (w_direct) begin
        dout       <= data_in;
        r_dout_par <= ~pkt_valid;
      end

      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      hold_count <= hold_count + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_hdr_ok) begin
        r_int_parity <= '0;
        r_ext_parity <= '0;
        r_pay_cnt    <= '0;
        hold_ovf     <= 1'b0;
        parity_done  <= 1'b0;
        err          <= 1'b0;
        len_err      <= 1'b0;
      end else begin
        if (lfd_state) begin
          r_int_parity <= r_int_parity ^ r_header;
          r_exp_len    <= r_header[DATA_W-1:ADDR_W];
        end else if (w_ld && pkt_valid) begin
          r_int_parity <= r_int_parity ^ data_in;
          if (r_pay_cnt != '1) r_pay_cnt <= r_pay_cnt + LEN_W'(1);
        end
        if (w_ld && !pkt_valid) r_ext_parity <= data_in;
        if (w_drop) hold_ovf <= 1'b1;
        if (dout_valid && r_dout_par) parity_done <= 1'b1;
        if (parity_done) begin
          err     <= (r_int_parity != r_ext_parity);
          len_err <= (r_pay_cnt != r_exp_len);
        end
      end

      if (rst_int_reg) begin
        low_packet_valid <= 1'b0;
      end else if (w_ld && !pkt_valid) begin
        low_packet_valid <= 1'b1;
      end
    end
  end

`ifdef ROUTER_REG_ERRSTAT_EN
  logic r_err_prev;
  logic r_len_err_prev;

  // Count rising edges only; err/len_err are cleared at each valid header.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_err_prev     <= 1'b0;
      r_len_err_prev <= 1'b0;
      err_cnt        <= '0;
      len_err_cnt    <= '0;
    end else begin
      r_err_prev     <= err;
      r_len_err_prev <= len_err;
      if (err && !r_err_prev && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (len_err && !r_len_err_prev && len_err_cnt != 16'hFFFF) begin
        len_err_cnt <= len_err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_reg_gen.sv
// Randomized scoreboard bench for router_reg_gen: a queue-level model predicts the dout stream,
// and a negedge monitor pops and compares each written byte.
module tb_router_reg_gen;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int NUM_PORTS  = 3;
  localparam int HOLD_DEPTH = 2;
  localparam int CNT_W      = $clog2(HOLD_DEPTH + 1);

  logic              clock = 1'b0;
  logic              resetn, pkt_valid, detect_add, lfd_state, ld_state, laf_state;
  logic              full_state, rst_int_reg, fifo_full;
  logic [DATA_W-1:0] data_in, dout;
  logic              dout_valid, invalid_addr, hold_ovf, low_packet_valid, parity_done;
  logic              err, len_err;
  logic [ADDR_W-1:0] dest_addr;
  logic [CNT_W-1:0]  hold_count;
`ifdef ROUTER_REG_ERRSTAT_EN
  logic [15:0]       err_cnt, len_err_cnt;
`endif

  router_reg_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS), .HOLD_DEPTH(HOLD_DEPTH)
  ) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .fifo_full(fifo_full), .dout(dout), .dout_valid(dout_valid), .dest_addr(dest_addr),
    .invalid_addr(invalid_addr), .hold_count(hold_count), .hold_ovf(hold_ovf),
    .low_packet_valid(low_packet_valid), .parity_done(parity_done), .err(err),
    .len_err(len_err)
`ifdef ROUTER_REG_ERRSTAT_EN
    , .err_cnt(err_cnt), .len_err_cnt(len_err_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {logic [7:0] b; logic par;} ent_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  ent_t       mq[$];
  logic [7:0] pay_buf[16];
  logic [1:0] m_dest = 2'd0;
  logic       m_ovf, m_par_out;
  int         m_err_cnt = 0;
  int         m_len_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dout_unexpected: got %0h expected no write", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout: got %0h expected %0h", dout, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic emit(input ent_t e);
    exp_q.push_back(e.b);
    if (e.par) m_par_out = 1'b1;
  endtask

  task automatic ld_byte(input logic [7:0] b, input logic is_par, input logic ff);
    ent_t n;
    n.b = b; n.par = is_par;
    ld_state = 1'b1; pkt_valid = ~is_par; data_in = b; fifo_full = ff;
    if (!ff) begin
      if (mq.size() == 0) emit(n);
      else begin
        emit(mq.pop_front());
        mq.push_back(n);
      end
    end else if (mq.size() < HOLD_DEPTH) mq.push_back(n);
    else m_ovf = 1'b1;
    step();
    chk("hold_count", 32'(hold_count), mq.size());
    ld_state = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    laf_state = 1'b1; fifo_full = 1'b1;
    step();
    chk("hold_count_laf_full", 32'(hold_count), mq.size());
    fifo_full = 1'b0;
    while (mq.size() > 0 && guard < 8) begin
      emit(mq.pop_front());
      step();
      chk("hold_count_drain", 32'(hold_count), mq.size());
      guard++;
    end
    laf_state = 1'b0;
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input int npay, input logic corrupt,
                         input int mask);
    logic [7:0] x, p;
    logic       exp_err, exp_len;
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    step();
    detect_add = 1'b0; pkt_valid = 1'b0;
    if (int'(hdr[1:0]) >= NUM_PORTS) begin
      chk("invalid_addr_pulse", 32'(invalid_addr), 1);
      chk("dest_addr_kept", 32'(dest_addr), 32'(m_dest));
      step();
      chk("invalid_addr_clear", 32'(invalid_addr), 0);
      return;
    end
    chk("invalid_addr_low", 32'(invalid_addr), 0);
    chk("dest_addr", 32'(dest_addr), 32'(hdr[1:0]));
    m_dest = hdr[1:0]; m_ovf = 1'b0; m_par_out = 1'b0;
    lfd_state = 1'b1; exp_q.push_back(hdr);
    step();
    lfd_state = 1'b0;
    x = hdr;
    for (int i = 0; i < npay; i++) begin
      x ^= pay_buf[i];
      ld_byte(pay_buf[i], 1'b0, mask[i]);
      if (mask[i] && $urandom_range(1, 0) == 1) begin
        full_state = 1'b1; fifo_full = 1'b1;
        step();
        chk("hold_count_full_state", 32'(hold_count), mq.size());
        full_state = 1'b0; fifo_full = 1'b0;
      end
    end
    p = corrupt ? (x ^ 8'h01) : x;
    ld_byte(p, 1'b1, mask[npay]);
    drain();
    repeat (4) step();
    exp_err = m_par_out && corrupt;
    exp_len = m_par_out && (npay != int'(hdr[7:2]));
    chk("parity_done", 32'(parity_done), 32'(m_par_out));
    chk("err", 32'(err), 32'(exp_err));
    chk("len_err", 32'(len_err), 32'(exp_len));
    chk("hold_ovf", 32'(hold_ovf), 32'(m_ovf));
    chk("low_packet_valid", 32'(low_packet_valid), 1);
`ifdef ROUTER_REG_ERRSTAT_EN
    if (exp_err) m_err_cnt++;
    if (exp_len) m_len_cnt++;
    chk("err_cnt", 32'(err_cnt), m_err_cnt);
    chk("len_err_cnt", 32'(len_err_cnt), m_len_cnt);
`endif
    rst_int_reg = 1'b1;
    step();
    rst_int_reg = 1'b0;
    chk("low_packet_valid_clr", 32'(low_packet_valid), 0);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; detect_add = 1'b0; lfd_state = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
    fifo_full = 1'b0;
    step(); step();
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dest_addr", 32'(dest_addr), 0);
    chk("rst_hold_count", 32'(hold_count), 0);
    chk("rst_flags", {27'd0, parity_done, err, len_err, hold_ovf, low_packet_valid}, 0);
    chk("rst_invalid_addr", 32'(invalid_addr), 0);
    resetn = 1'b1;

    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    run_pkt(8'h0D, 3, 1'b0, 0);       // clean packet
    run_pkt(8'h0D, 3, 1'b1, 0);       // parity 0C
    run_pkt(8'h0B, 0, 1'b0, 0);       // bad address
    run_pkt(8'h0D, 3, 1'b0, 32'h6);   // 22,33 held then drained
    run_pkt(8'h0D, 3, 1'b0, 32'h7);   // third byte dropped
    run_pkt(8'h11, 3, 1'b0, 0);       // length 4, 3 bytes sent

    // Reset in the middle of a packet with bytes held.
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0E;
    step();
    detect_add = 1'b0; pkt_valid = 1'b0;
    lfd_state = 1'b1; exp_q.push_back(8'h0E);
    step();
    lfd_state = 1'b0;
    ld_byte(8'hA1, 1'b0, 1'b1);
    ld_byte(8'hA2, 1'b0, 1'b1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mq.delete(); m_dest = 2'd0; m_err_cnt = 0; m_len_cnt = 0;
    chk("midrst_hold_count", 32'(hold_count), 0);
    chk("midrst_dest_addr", 32'(dest_addr), 0);
    chk("midrst_dout_valid", 32'(dout_valid), 0);
`ifdef ROUTER_REG_ERRSTAT_EN
    chk("midrst_err_cnt", 32'(err_cnt), 0);
`endif

    for (int k = 0; k < 40; k++) begin
      int         len, npay, mask;
      logic [7:0] hdr;
      len  = $urandom_range(5, 0);
      npay = ($urandom_range(3, 0) == 0) ? $urandom_range(6, 0) : len;
      hdr  = {6'(len), 2'($urandom_range(3, 0))};
      for (int i = 0; i < npay; i++) pay_buf[i] = 8'($urandom);
      mask = ($urandom_range(1, 0) == 1) ? int'($urandom) : 0;
      run_pkt(hdr, npay, ($urandom_range(2, 0) == 0), mask);
    end

    step(); step();
    chk("dout_all_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
